mem_field_reader: RTL and testbench
===================================

MEM_FIELD_READER -- requirements
Module: mem_field_reader

Interface
REQ-001 Parameter N, default 32, SHALL set the stored word width in bits.
REQ-002 Parameter DEPTH, default 1025, SHALL set the number of words, addresses 0..DEPTH-1.
REQ-003 Parameter AW, default 11, SHALL set the address width, with 2^AW >= DEPTH.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-006 wr_en  input  1  SHALL be the full-word write strobe, accepted every cycle it is high.
REQ-007 wr_addr  input  AW  SHALL be the write address.
REQ-008 wr_data  input  N  SHALL be the write data.
REQ-009 rd_req  input  1  SHALL be the field-read request, accepted only when rd_busy=0.
REQ-010 rd_addr  input  AW  SHALL be the read word address.
REQ-011 rd_lsb  input  5  SHALL be the field's least significant bit index.
REQ-012 rd_len  input  6  SHALL be the field length in bits, legal range 1..N.
REQ-013 rd_ack  input  1  SHALL be the consumer acknowledge of the response.
REQ-014 rd_busy  output  1  SHALL be high whenever a read is in progress (state not IDLE).
REQ-015 rd_valid  output  1  SHALL be high while a response is presented.
REQ-016 rd_data  output  N  SHALL carry the extracted field, right-justified and zero-extended.
REQ-017 rd_err  output  1  SHALL flag an illegal request; valid only with rd_valid.
REQ-018 evt_count  output  16  SHALL count accepted writes; wraps from 16'hFFFF to 0.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH, EXTRACT and RESP.
REQ-020 IDLE -> FETCH SHALL occur on rd_req=1; rd_addr, rd_lsb and rd_len are latched in that cycle.
REQ-021 FETCH SHALL register the addressed word; FETCH -> EXTRACT unconditionally.
REQ-022 EXTRACT SHALL compute rd_data = (word >> lsb) masked to len bits; EXTRACT -> RESP unconditionally.
REQ-023 Latency: with a request accepted at edge T, rd_valid SHALL rise at edge T+3 (three cycles).
REQ-024 RESP SHALL hold rd_valid, rd_data and rd_err stable until rd_ack=1, then go to IDLE with rd_valid=0 on the next edge.
REQ-025 rd_req while rd_busy=1 SHALL be ignored and not queued.
REQ-026 rd_ack outside RESP SHALL be ignored.
REQ-027 Illegal request (latched address >= DEPTH, len=0, or lsb+len > N) SHALL yield rd_err=1 and rd_data=0 with normal latency; memory is not read.
REQ-028 len=N with lsb=0 SHALL return the full word; the mask SHALL be computed without overflow at len=N.
REQ-029 A write in the same cycle as FETCH to the same address SHALL be invisible to that read (read-first); writes in earlier cycles SHALL be visible.
REQ-030 Writes SHALL continue during any read state; a write to address >= DEPTH SHALL be dropped and SHALL NOT increment evt_count.
REQ-031 Write data wider than the value supplied is the driver's concern; wr_data is stored as all N bits, with no partial-word writes.

Reset
REQ-032 Reset SHALL force state IDLE, rd_busy=0, rd_valid=0, rd_data=0, rd_err=0 and evt_count=0 on the next edge, in any state, including mid-RESP.
REQ-033 A wr_en asserted in a reset cycle SHALL be ignored.
REQ-034 Reset SHALL NOT initialise memory contents; unwritten words read as unknown.

Verification
REQ-035 Write 32'h12345678 to addr 0, then read lsb=0 len=8 -> rd_data=32'h00000078, rd_err=0, rd_valid 3 cycles after acceptance.
REQ-036 Same word, read lsb=8 len=8 -> 32'h00000056; lsb=16 len=8 -> 32'h00000034; lsb=0 len=32 -> 32'h12345678.
REQ-037 Write 32'h000000AA to addr 0, then read lsb=0 len=32 -> 32'h000000AA; evt_count=2.
REQ-038 Read addr 1025 or len=0 or lsb=28 len=8 -> rd_err=1, rd_data=0; hold rd_ack=0 for 5 cycles, so rd_valid and data stay stable; then ack -> IDLE.
REQ-039 During FETCH of addr 5 (holding 32'h11111111), write 32'h22222222 to addr 5 -> response 32'h11111111; a re-read -> 32'h22222222.
REQ-040 Assert reset during RESP -> next edge rd_valid=0, rd_busy=0, evt_count=0; a new request completes normally.

Source files
------------

// File: rtl/mem_field_reader_if.sv
// Handshake/bus bundle between a field-read client and mem_field_reader.
// The master drives writes, read requests and acknowledges; the slave returns
// the busy/valid status, the extracted field, the error flag and the write count.
interface mem_field_reader_if #(
  parameter int N  = 32,
  parameter int AW = 11
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [N-1:0]  wr_data;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [4:0]    rd_lsb;
  logic [5:0]    rd_len;
  logic          rd_ack;
  logic          rd_busy;
  logic          rd_valid;
  logic [N-1:0]  rd_data;
  logic          rd_err;
  logic [15:0]   evt_count;

  modport master (
    output wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_lsb, rd_len, rd_ack,
    input  rd_busy, rd_valid, rd_data, rd_err, evt_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_req, rd_addr, rd_lsb, rd_len, rd_ack,
    output rd_busy, rd_valid, rd_data, rd_err, evt_count
  );
endinterface

// File: rtl/mem_field_reader.sv
// Word memory with a bit-field read port: extracts (word >> lsb) masked to len bits.
// Latency: rd_valid rises three edges after the accepting edge; writes take one edge.
// Backpressure: the response is held until rd_ack; new requests are ignored while busy.
module mem_field_reader #(
  parameter int N     = 32,
  parameter int DEPTH = 1025,
  parameter int AW    = 11
) (
  input  logic               clk,
  input  logic               reset,
  mem_field_reader_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FETCH, EXTRACT, RESP} state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [6:0]  N_W     = 7'(N);

  state_t        state;
  logic [N-1:0]  mem [DEPTH];
  logic [AW-1:0] addr_q;
  logic [4:0]    lsb_q;
  logic [5:0]    len_q;
  logic [N-1:0]  word_q;
  logic [N-1:0]  field_q;
  logic          err_q;
  logic          rd_valid_q;
  logic [N-1:0]  rd_data_q;
  logic          rd_err_q;
  logic [15:0]   evt_q;

  logic          wr_ok;
  logic          req_err;
  logic [N-1:0]  mask;
  logic [N-1:0]  field;

  // Out-of-range writes are dropped and are not counted.
  assign wr_ok = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_W);

  // Legality of the latched request; the 7-bit sum cannot overflow (31 + 63).
  assign req_err = ({1'b0, addr_q} >= DEPTH_W) || (len_q == 6'd0) ||
                   (({2'b00, lsb_q} + {1'b0, len_q}) > N_W);

  // Field mask; len = N takes the all-ones default so no shift reaches N.
  always_comb begin
    mask = '1;
    if ({1'b0, len_q} < N_W) mask = ~({N{1'b1}} << len_q);
    field = (word_q >> lsb_q) & mask;
  end

  // Memory write port; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok) mem[bus.wr_addr] <= bus.wr_data;
  end

  // Read FSM with registered response outputs and the write event counter.
  // EXTRACT registers the field, RESP's first cycle moves it to the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      lsb_q      <= '0;
      len_q      <= '0;
      word_q     <= '0;
      field_q    <= '0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
      evt_q      <= '0;
    end else begin
      if (wr_ok) evt_q <= evt_q + 16'd1;
      case (state)
        IDLE: begin
          if (bus.rd_req) begin
            addr_q <= bus.rd_addr;
            lsb_q  <= bus.rd_lsb;
            len_q  <= bus.rd_len;
            state  <= FETCH;
          end
        end
        FETCH: begin
          // Old contents win against a same-cycle write (read-first).
          err_q <= req_err;
          if (!req_err) word_q <= mem[addr_q];
          state <= EXTRACT;
        end
        EXTRACT: begin
          field_q <= err_q ? '0 : field;
          state   <= RESP;
        end
        RESP: begin
          if (!rd_valid_q) begin
            rd_valid_q <= 1'b1;
            rd_data_q  <= field_q;
            rd_err_q   <= err_q;
          end else if (bus.rd_ack) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.rd_busy   = (state != IDLE);
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.evt_count = evt_q;

endmodule

// File: tb/tb_mem_field_reader.sv
// Directed bench for mem_field_reader: field extraction, latency, errors,
// read-first collision, ignored requests while busy and reset during a response.
module tb_mem_field_reader;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  mem_field_reader_if #(.N(32), .AW(11)) bus ();

  mem_field_reader #(.N(32), .DEPTH(1025), .AW(11)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Single write on one rising edge.
  task automatic do_write(input logic [10:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  // Runs one read transaction and returns what was observed; the callers compare.
  task automatic read_txn(
    input  logic [10:0] a, input logic [4:0] l, input logic [5:0] n, input int hold,
    input  logic poke, input logic fw, input logic [10:0] fw_a, input logic [31:0] fw_d,
    output logic v_t2, output logic v_t3, output logic [31:0] d, output logic e,
    output logic stable, output logic idle_after);
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = a; bus.rd_lsb = l; bus.rd_len = n;
    @(posedge clk); #1;                    // edge T: accepted
    bus.rd_req = 1'b0;
    if (fw) begin bus.wr_en = 1'b1; bus.wr_addr = fw_a; bus.wr_data = fw_d; end
    @(posedge clk); #1;                    // edge T+1
    bus.wr_en = 1'b0;
    if (poke) begin bus.rd_req = 1'b1; bus.rd_addr = 11'd5; bus.rd_lsb = 5'd0; bus.rd_len = 6'd32; end
    @(posedge clk); #1;                    // edge T+2
    bus.rd_req = 1'b0;
    v_t2 = bus.rd_valid;
    @(posedge clk); #1;                    // edge T+3
    v_t3 = bus.rd_valid; d = bus.rd_data; e = bus.rd_err; stable = 1'b1;
    repeat (hold) begin
      @(posedge clk); #1;
      if (bus.rd_valid !== 1'b1 || bus.rd_data !== d || bus.rd_err !== e) stable = 1'b0;
    end
    bus.rd_ack = 1'b1;
    @(posedge clk); #1;
    bus.rd_ack = 1'b0;
    idle_after = (bus.rd_valid === 1'b0) && (bus.rd_busy === 1'b0);
    @(posedge clk); #1;
    if (bus.rd_busy !== 1'b0) idle_after = 1'b0;
  endtask

  task automatic test_reset();
    bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0; bus.rd_req = 0;
    bus.rd_addr = '0; bus.rd_lsb = '0; bus.rd_len = '0; bus.rd_ack = 0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.rd_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.rd_busy); end
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_data !== 32'h0) begin fails++; $display("FAIL reset_data got %h want 0", bus.rd_data); end
    checks++; if (bus.rd_err !== 1'b0) begin fails++; $display("FAIL reset_err got %b want 0", bus.rd_err); end
    checks++; if (bus.evt_count !== 16'h0) begin fails++; $display("FAIL reset_evt got %h want 0", bus.evt_count); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_extract();
    logic [4:0]  lsbs [8] = '{5'd0, 5'd8, 5'd16, 5'd0, 5'd24, 5'd4, 5'd31, 5'd7};
    logic [5:0]  lens [8] = '{6'd8, 6'd8, 6'd8, 6'd32, 6'd8, 6'd28, 6'd1, 6'd1};
    logic [31:0] exps [8] = '{32'h78, 32'h56, 32'h34, 32'h12345678, 32'h12, 32'h01234567, 32'h0, 32'h1};
    logic v2, v3, e, st, idl;
    logic [31:0] d;
    do_write(11'd0, 32'h12345678);
    checks++; if (bus.evt_count !== 16'd1) begin fails++; $display("FAIL evt_after_first_write got %0d want 1", bus.evt_count); end
    for (int i = 0; i < 8; i++) begin
      if (i == 6) do_write(11'd0, 32'h000000AA);
      read_txn(11'd0, lsbs[i], lens[i], 0, 1'b0, 1'b0, 11'd0, 32'h0, v2, v3, d, e, st, idl);
      checks++; if (v2 !== 1'b0) begin fails++; $display("FAIL extract%0d_valid_early got %b want 0", i, v2); end
      checks++; if (v3 !== 1'b1) begin fails++; $display("FAIL extract%0d_valid_t3 got %b want 1", i, v3); end
      checks++; if (d !== exps[i]) begin fails++; $display("FAIL extract%0d_data got %h want %h", i, d, exps[i]); end
      checks++; if (e !== 1'b0) begin fails++; $display("FAIL extract%0d_err got %b want 0", i, e); end
      checks++; if (idl !== 1'b1) begin fails++; $display("FAIL extract%0d_idle got %b want 1", i, idl); end
    end
    read_txn(11'd0, 5'd0, 6'd32, 0, 1'b0, 1'b0, 11'd0, 32'h0, v2, v3, d, e, st, idl);
    checks++; if (d !== 32'h000000AA) begin fails++; $display("FAIL rewrite_full_word got %h want 000000aa", d); end
    checks++; if (bus.evt_count !== 16'd2) begin fails++; $display("FAIL evt_after_two_writes got %0d want 2", bus.evt_count); end
  endtask

  task automatic test_errors();
    logic [10:0] addrs [3] = '{11'd1025, 11'd0, 11'd0};
    logic [4:0]  lsbs  [3] = '{5'd0, 5'd0, 5'd28};
    logic [5:0]  lens  [3] = '{6'd8, 6'd0, 6'd8};
    logic v2, v3, e, st, idl;
    logic [31:0] d;
    do_write(11'd1025, 32'hFFFFFFFF);
    do_write(11'd2047, 32'hFFFFFFFF);
    checks++; if (bus.evt_count !== 16'd2) begin fails++; $display("FAIL dropped_write_evt got %0d want 2", bus.evt_count); end
    for (int i = 0; i < 3; i++) begin
      read_txn(addrs[i], lsbs[i], lens[i], 5, 1'b0, 1'b0, 11'd0, 32'h0, v2, v3, d, e, st, idl);
      checks++; if (v3 !== 1'b1) begin fails++; $display("FAIL err%0d_valid_t3 got %b want 1", i, v3); end
      checks++; if (e !== 1'b1) begin fails++; $display("FAIL err%0d_flag got %b want 1", i, e); end
      checks++; if (d !== 32'h0) begin fails++; $display("FAIL err%0d_data got %h want 0", i, d); end
      checks++; if (st !== 1'b1) begin fails++; $display("FAIL err%0d_hold_stable got %b want 1", i, st); end
      checks++; if (idl !== 1'b1) begin fails++; $display("FAIL err%0d_idle_after_ack got %b want 1", i, idl); end
    end
  endtask

  task automatic test_read_first();
    logic v2, v3, e, st, idl;
    logic [31:0] d;
    do_write(11'd5, 32'h11111111);
    read_txn(11'd5, 5'd0, 6'd32, 0, 1'b0, 1'b1, 11'd5, 32'h22222222, v2, v3, d, e, st, idl);
    checks++; if (d !== 32'h11111111) begin fails++; $display("FAIL read_first_old got %h want 11111111", d); end
    checks++; if (bus.evt_count !== 16'd4) begin fails++; $display("FAIL write_during_fetch_evt got %0d want 4", bus.evt_count); end
    read_txn(11'd5, 5'd0, 6'd32, 0, 1'b0, 1'b0, 11'd0, 32'h0, v2, v3, d, e, st, idl);
    checks++; if (d !== 32'h22222222) begin fails++; $display("FAIL reread_new got %h want 22222222", d); end
  endtask

  task automatic test_busy_ignored();
    logic v2, v3, e, st, idl;
    logic [31:0] d;
    // Ack with no response pending must not disturb the idle FSM.
    @(negedge clk); bus.rd_ack = 1'b1;
    @(negedge clk); bus.rd_ack = 1'b0;
    checks++; if (bus.rd_busy !== 1'b0) begin fails++; $display("FAIL stray_ack_busy got %b want 0", bus.rd_busy); end
    read_txn(11'd0, 5'd4, 6'd4, 2, 1'b1, 1'b0, 11'd0, 32'h0, v2, v3, d, e, st, idl);
    checks++; if (d !== 32'h0000000A) begin fails++; $display("FAIL busy_req_data got %h want 0000000a", d); end
    checks++; if (idl !== 1'b1) begin fails++; $display("FAIL busy_req_not_queued got %b want 1", idl); end
  endtask

  task automatic test_reset_in_resp();
    logic v2, v3, e, st, idl;
    logic [31:0] d;
    do_write(11'd7, 32'hA5A5A5A5);
    @(negedge clk);
    bus.rd_req = 1'b1; bus.rd_addr = 11'd0; bus.rd_lsb = 5'd0; bus.rd_len = 6'd32;
    @(posedge clk); #1;
    bus.rd_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.rd_valid !== 1'b1) begin fails++; $display("FAIL pre_reset_valid got %b want 1", bus.rd_valid); end
    @(negedge clk);
    reset = 1'b1; bus.wr_en = 1'b1; bus.wr_addr = 11'd7; bus.wr_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    checks++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL resp_reset_valid got %b want 0", bus.rd_valid); end
    checks++; if (bus.rd_busy !== 1'b0) begin fails++; $display("FAIL resp_reset_busy got %b want 0", bus.rd_busy); end
    checks++; if (bus.evt_count !== 16'h0) begin fails++; $display("FAIL resp_reset_evt got %h want 0", bus.evt_count); end
    checks++; if (bus.rd_data !== 32'h0) begin fails++; $display("FAIL resp_reset_data got %h want 0", bus.rd_data); end
    @(negedge clk);
    reset = 1'b0; bus.wr_en = 1'b0;
    read_txn(11'd7, 5'd0, 6'd32, 0, 1'b0, 1'b0, 11'd0, 32'h0, v2, v3, d, e, st, idl);
    checks++; if (v3 !== 1'b1) begin fails++; $display("FAIL post_reset_valid got %b want 1", v3); end
    checks++; if (d !== 32'hA5A5A5A5) begin fails++; $display("FAIL reset_write_ignored got %h want a5a5a5a5", d); end
    checks++; if (bus.evt_count !== 16'h0) begin fails++; $display("FAIL post_reset_evt got %h want 0", bus.evt_count); end
  endtask

  initial begin
    test_reset();
    test_extract();
    test_errors();
    test_read_first();
    test_busy_ignored();
    test_reset_in_resp();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1, "timeout");
  end

endmodule
